// File: rtl/dp_ram_be.sv
// Dual-port RAM with per-lane byte enables, selectable read latency,
// cross-port read-during-write behaviour and an optional zero-fill sequencer.
module dp_ram_be #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            wdata_a,
  output logic [DATA_WIDTH-1:0]            rdata_a,
  output logic                             rvalid_a,
  input  logic                             en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            wdata_b,
  output logic [DATA_WIDTH-1:0]            rdata_b,
  output logic                             rvalid_b,
  output logic                             busy,
  output logic                             collision
);

  localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   cnt, cnt_next;
  logic                  run;
  logic                  rd_a, wr_a, rd_b, wr_b;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
  logic [DATA_WIDTH-1:0] rdata_a1, rdata_b1;
  logic                  rvalid_a1, rvalid_b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Fill sequencer state and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Fill next-state: the extra counter bit marks that DEPTH-1 has been written
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == INIT) begin
      cnt_next = cnt + (ADDR_WIDTH + 1)'(1);
      if (cnt_next[ADDR_WIDTH]) state_next = RUN;
    end
  end

  assign busy = (state == INIT);
  assign run  = !busy;
  assign rd_a = run && en_a && (we_a == '0);
  assign wr_a = run && en_a && (we_a != '0);
  assign rd_b = run && en_b && (we_b == '0);
  assign wr_b = run && en_b && (we_b != '0);

  // Array update: port B lanes first so port A overrides on shared lanes
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt[ADDR_WIDTH-1:0]] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++)
        if (wr_b && we_b[i])
          mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      for (int unsigned i = 0; i < NB; i++)
        if (wr_a && we_a[i])
          mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Port A read word, optionally forwarding port B's write lanes
  always_comb begin
    rd_word_a = mem[addr_a];
    if ((RDW_MODE != 0) && wr_b && (addr_b == addr_a))
      for (int unsigned i = 0; i < NB; i++)
        if (we_b[i]) rd_word_a[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_b[i*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // Port B read word, optionally forwarding port A's write lanes
  always_comb begin
    rd_word_b = mem[addr_b];
    if ((RDW_MODE != 0) && wr_a && (addr_a == addr_b))
      for (int unsigned i = 0; i < NB; i++)
        if (we_a[i]) rd_word_b[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // First read stage; data holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a1  <= '0;
      rdata_b1  <= '0;
      rvalid_a1 <= 1'b0;
      rvalid_b1 <= 1'b0;
    end else begin
      rvalid_a1 <= rd_a;
      rvalid_b1 <= rd_b;
      if (rd_a) rdata_a1 <= rd_word_a;
      if (rd_b) rdata_b1 <= rd_word_b;
    end
  end

  // Same-address conflict flag, registered one cycle after the requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= run && en_a && en_b && (addr_a == addr_b) && (wr_a || wr_b);
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rdata_a2, rdata_b2;
    logic                  rvalid_a2, rvalid_b2;

    // Optional second output stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_a2  <= '0;
        rdata_b2  <= '0;
        rvalid_a2 <= 1'b0;
        rvalid_b2 <= 1'b0;
      end else begin
        rvalid_a2 <= rvalid_a1;
        rvalid_b2 <= rvalid_b1;
        if (rvalid_a1) rdata_a2 <= rdata_a1;
        if (rvalid_b1) rdata_b2 <= rdata_b1;
      end
    end

    assign rdata_a  = rdata_a2;
    assign rdata_b  = rdata_b2;
    assign rvalid_a = rvalid_a2;
    assign rvalid_b = rvalid_b2;
  end else begin : g_lat1
    assign rdata_a  = rdata_a1;
    assign rdata_b  = rdata_b1;
    assign rvalid_a = rvalid_a1;
    assign rvalid_b = rvalid_b1;
  end

endmodule

// File: tb/tb_dp_ram_be.sv
// Directed testbench for dp_ram_be: three instances share one stimulus
// (latency 1/old-data, latency 2/new-data, latency 1 without zero fill).
module tb_dp_ram_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;

  logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1, rdata_a2, rdata_b2;
  logic        rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1, rvalid_a2, rvalid_b2;
  logic        busy0, busy1, busy2, col0, col1, col2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1),
              .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
    .busy(busy0), .collision(col0));

  dp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2),
              .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
    .busy(busy1), .collision(col1));

  dp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1),
              .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a2), .rvalid_a(rvalid_a2),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b2), .rvalid_b(rvalid_b2),
    .busy(busy2), .collision(col2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 4'h0; addr_a = 4'h0; wdata_a = 32'h0;
    en_b = 1'b0; we_b = 4'h0; addr_b = 4'h0; wdata_b = 32'h0;
  endtask

  task automatic port_a(input logic [3:0] we, input logic [3:0] addr, input logic [31:0] d);
    en_a = 1'b1; we_a = we; addr_a = addr; wdata_a = d;
  endtask

  task automatic port_b(input logic [3:0] we, input logic [3:0] addr, input logic [31:0] d);
    en_b = 1'b1; we_b = we; addr_b = addr; wdata_b = d;
  endtask

  // Count busy cycles after release; requests driven meanwhile must be dropped
  task automatic count_fill(input string tag, input bit with_traffic);
    int busy_cycles = 0;
    bit leak = 1'b0;
    if (with_traffic) begin
      port_a(4'hF, 4'd2, 32'hFFFF_FFFF);
      port_b(4'h0, 4'd2, 32'h0);
    end
    while (busy0 && busy_cycles < 100) begin
      busy_cycles++;
      step();
      if (rvalid_a0 || rvalid_b0 || col0 || rvalid_a1 || rvalid_b1 || col1) leak = 1'b1;
    end
    idle();
    checks++;
    if (busy_cycles !== 16) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d exp=16", tag, busy_cycles);
    end
    checks++;
    if (leak !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_dropped got=%0b exp=0", tag, leak);
    end
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy1_end got=%0b exp=0", tag, busy1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    checks++;
    if ({rvalid_a0, rvalid_b0, col0, busy0} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_flags0 got=%b exp=0001", {rvalid_a0, rvalid_b0, col0, busy0});
    end
    checks++;
    if ({rdata_a0, rdata_b0, rdata_a1, rdata_b1} !== 128'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", {rdata_a0, rdata_b0, rdata_a1, rdata_b1});
    end
    checks++;
    if ({busy1, busy2} !== 2'b10) begin
      failures++;
      $display("FAIL reset_busy12 got=%b exp=10", {busy1, busy2});
    end
    rst_n = 1'b1;
    count_fill("init", 1'b1);
    checks++;
    if (busy2 !== 1'b0) begin
      failures++;
      $display("FAIL noclear_busy got=%0b exp=0", busy2);
    end
  endtask

  task automatic test_fill();
    port_a(4'h0, 4'd15, 32'h0);
    port_b(4'h0, 4'd2, 32'h0);
    step();
    idle();
    checks++;
    if ({rvalid_a0, rvalid_b0} !== 2'b11 || rdata_a0 !== 32'h0 || rdata_b0 !== 32'h0) begin
      failures++;
      $display("FAIL fill_lat1 got=%b/%h/%h exp=11/0/0", {rvalid_a0, rvalid_b0}, rdata_a0, rdata_b0);
    end
    checks++;
    if ({rvalid_a1, rvalid_b1} !== 2'b00) begin
      failures++;
      $display("FAIL fill_lat2_early got=%b exp=00", {rvalid_a1, rvalid_b1});
    end
    step();
    checks++;
    if ({rvalid_a1, rvalid_b1} !== 2'b11 || rdata_a1 !== 32'h0 || rdata_b1 !== 32'h0) begin
      failures++;
      $display("FAIL fill_lat2 got=%b/%h/%h exp=11/0/0", {rvalid_a1, rvalid_b1}, rdata_a1, rdata_b1);
    end
    checks++;
    if ({rvalid_a0, rvalid_b0} !== 2'b00) begin
      failures++;
      $display("FAIL fill_pulse got=%b exp=00", {rvalid_a0, rvalid_b0});
    end
  endtask

  task automatic test_byte_enable();
    port_a(4'hF, 4'd3, 32'hAABB_CCDD);
    step();
    checks++;
    if ({rvalid_a0, rvalid_b0} !== 2'b00) begin
      failures++;
      $display("FAIL write_no_rvalid got=%b exp=00", {rvalid_a0, rvalid_b0});
    end
    port_a(4'b0101, 4'd3, 32'h1122_3344);
    step();
    idle();
    port_b(4'h0, 4'd3, 32'h0);
    step();
    idle();
    checks++;
    if (rvalid_b0 !== 1'b1 || rdata_b0 !== 32'hAA22_CC44) begin
      failures++;
      $display("FAIL be_lat1 got=%b/%h exp=1/aa22cc44", rvalid_b0, rdata_b0);
    end
    checks++;
    if (rvalid_b2 !== 1'b1 || rdata_b2 !== 32'hAA22_CC44) begin
      failures++;
      $display("FAIL be_noclear got=%b/%h exp=1/aa22cc44", rvalid_b2, rdata_b2);
    end
    step();
    checks++;
    if (rvalid_b1 !== 1'b1 || rdata_b1 !== 32'hAA22_CC44) begin
      failures++;
      $display("FAIL be_lat2 got=%b/%h exp=1/aa22cc44", rvalid_b1, rdata_b1);
    end
    checks++;
    if (rvalid_b0 !== 1'b0 || rdata_b0 !== 32'hAA22_CC44) begin
      failures++;
      $display("FAIL be_hold got=%b/%h exp=0/aa22cc44", rvalid_b0, rdata_b0);
    end
  endtask

  task automatic test_dual_write();
    port_a(4'b1100, 4'd5, 32'h1234_5678);
    port_b(4'b0110, 4'd5, 32'h9ABC_DEF0);
    step();
    idle();
    checks++;
    if ({col0, col1} !== 2'b11) begin
      failures++;
      $display("FAIL dw_collision got=%b exp=11", {col0, col1});
    end
    port_a(4'h0, 4'd5, 32'h0);
    step();
    idle();
    checks++;
    if (col0 !== 1'b0) begin
      failures++;
      $display("FAIL dw_collision_pulse got=%b exp=0", col0);
    end
    checks++;
    if (rvalid_a0 !== 1'b1 || rdata_a0 !== 32'h1234_DE00) begin
      failures++;
      $display("FAIL dw_data0 got=%b/%h exp=1/1234de00", rvalid_a0, rdata_a0);
    end
    step();
    checks++;
    if (rvalid_a1 !== 1'b1 || rdata_a1 !== 32'h1234_DE00) begin
      failures++;
      $display("FAIL dw_data1 got=%b/%h exp=1/1234de00", rvalid_a1, rdata_a1);
    end
    port_a(4'h0, 4'd5, 32'h0);
    port_b(4'h0, 4'd5, 32'h0);
    step();
    idle();
    checks++;
    if ({col0, rvalid_a0, rvalid_b0} !== 3'b011 || rdata_b0 !== 32'h1234_DE00) begin
      failures++;
      $display("FAIL dual_read got=%b/%h exp=011/1234de00", {col0, rvalid_a0, rvalid_b0}, rdata_b0);
    end
    step();
  endtask

  task automatic test_rdw();
    port_a(4'hF, 4'd7, 32'hCAFE_F00D);
    port_b(4'h0, 4'd7, 32'h0);
    step();
    idle();
    checks++;
    if (rvalid_b0 !== 1'b1 || rdata_b0 !== 32'h0 || col0 !== 1'b1) begin
      failures++;
      $display("FAIL rdw_old got=%b/%h/%b exp=1/00000000/1", rvalid_b0, rdata_b0, col0);
    end
    step();
    checks++;
    if (rvalid_b1 !== 1'b1 || rdata_b1 !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL rdw_new got=%b/%h exp=1/cafef00d", rvalid_b1, rdata_b1);
    end
    port_a(4'h0, 4'd7, 32'h0);
    step();
    idle();
    checks++;
    if (rdata_a0 !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL raw_same_port got=%h exp=cafef00d", rdata_a0);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    for (int i = 0; i < 3; i++) begin
      port_a(4'hF, 4'(i), 32'hD000_0000 + 32'(i));
      exp[i] = 32'hD000_0000 + 32'(i);
      step();
    end
    exp[3] = 32'hAA22_CC44;
    idle();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) port_b(4'h0, 4'(c), 32'h0);
      else idle();
      step();
      if (c < 4) begin
        checks++;
        if (rvalid_b0 !== 1'b1 || rdata_b0 !== exp[c]) begin
          failures++;
          $display("FAIL b2b_lat1[%0d] got=%b/%h exp=1/%h", c, rvalid_b0, rdata_b0, exp[c]);
        end
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (rvalid_b1 !== 1'b1 || rdata_b1 !== exp[c-1]) begin
          failures++;
          $display("FAIL b2b_lat2[%0d] got=%b/%h exp=1/%h", c, rvalid_b1, rdata_b1, exp[c-1]);
        end
      end else begin
        checks++;
        if (rvalid_b1 !== 1'b0) begin
          failures++;
          $display("FAIL b2b_lat2_idle[%0d] got=%b exp=0", c, rvalid_b1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    port_b(4'h0, 4'd0, 32'h0);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid_b0, rvalid_b1, busy0, busy1, busy2} !== 5'b00110) begin
      failures++;
      $display("FAIL mid_reset_async got=%b exp=00110", {rvalid_b0, rvalid_b1, busy0, busy1, busy2});
    end
    step();
    step();
    checks++;
    if ({rvalid_b0, rvalid_b1} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_late got=%b exp=00", {rvalid_b0, rvalid_b1});
    end
    rst_n = 1'b1;
    count_fill("reinit", 1'b0);
    port_a(4'h0, 4'd3, 32'h0);
    step();
    idle();
    checks++;
    if (rvalid_a0 !== 1'b1 || rdata_a0 !== 32'h0) begin
      failures++;
      $display("FAIL reinit_cleared got=%b/%h exp=1/00000000", rvalid_a0, rdata_a0);
    end
    step();
    checks++;
    if (rvalid_a1 !== 1'b1 || rdata_a1 !== 32'h0) begin
      failures++;
      $display("FAIL reinit_cleared_lat2 got=%b/%h exp=1/00000000", rvalid_a1, rdata_a1);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_byte_enable();
    test_dual_write();
    test_rdw();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
